lm32_mult_pipe: RTL
===================

// Module: lm32_mult_pipe
// PURPOSE
//  Parametrised, handshaked pipelined multiplier; successor to the fixed 32x32 low-word unit in the X/M path.
//  Adds signed/unsigned operand modes, high/low result select, configurable depth, valid/ready flow control and kill.
//  Sits beside the LM32 ALU; also reusable by NoC-side DSP tiles. Integer only, one issue per cycle max.
// PARAMETERS
//  WIDTH   32  operand and result width in bits (>=8)
//  STAGES  3   register stages input->result (2..6); 2 = operand reg + result reg
// PORTS
//  clk_i        in   1      clock, all state on rising edge
//  rst_i        in   1      reset, asynchronous, active-low
//  in_valid_i   in   1      operands/mode valid
//  in_ready_o   out  1      pipeline can accept this cycle
//  op_a_i       in   WIDTH  multiplicand
//  op_b_i       in   WIDTH  multiplier
//  a_signed_i   in   1      1: op_a two's complement
//  b_signed_i   in   1      1: op_b two's complement
//  high_i       in   1      1: return bits [2W-1:W]; 0: bits [W-1:0]
//  kill_i       in   1      discard every in-flight and same-cycle operation
//  out_valid_o  out  1      result_o valid
//  out_ready_i  in   1      consumer accepts result
//  result_o     out  WIDTH  selected product half
//  ovf_o        out  1      overflow flag (LM32_MULT_OVF_EN only; else tied 0)
// BEHAVIOUR
//  - Reset (rst_i low, async): all stage valid bits 0, all data regs 0; out_valid_o=0, result_o=0, ovf_o=0.
//  - Product: each operand extended to WIDTH+1 bits (sign bit if *_signed_i else 0); full 2*WIDTH product
//    of the extended values; truncate to 2*WIDTH; select half per high_i. Mode bits travel with the data.
//  - Stage k holds {valid_k, data_k}. Stage last = output register driving out_valid_o/result_o.
//  - Advance rule: stage k loads from k-1 iff (!valid_k || adv_{k+1}); adv_out = out_valid_o && out_ready_i.
//    in_ready_o = !valid_0 || adv_1 (combinational, bubble-collapsing; no combinational in_valid->out path).
//  - Stage k not loading holds data and valid; on load with upstream empty, valid_k<=0.
//  - Accept iff in_valid_i && in_ready_o && !kill_i. Latency: accepted on edge t -> out_valid_o after edge t+STAGES-1
//    with no backpressure; throughput 1/cycle with out_ready_i held 1.
//  - Backpressure: result_o/out_valid_o stable while out_valid_o && !out_ready_i; full pipe holds STAGES ops.
//  - kill_i: next edge all valid bits 0 (including output stage, even if out_ready_i same cycle); same-cycle input
//    dropped; data regs need not clear. kill_i and out_ready_i together: the output is not considered consumed.
//  - Reset mid-operation: everything discarded, no partial result ever presented.
//  - Multiply itself placed between stage 0 and stage 1; stages 2..last are pure pipeline (retiming by synthesis).
// CONFIGURATION
//  LM32_MULT_OVF_EN defined: ovf_o registered alongside result_o; for high_i=0, ovf_o=1 when the full product does not
//   fit WIDTH bits in the result's signedness (signed if a_signed_i||b_signed_i: bits [2W-1:W-1] not all equal;
//   unsigned: bits [2W-1:W] nonzero). For high_i=1, ovf_o=0.
//  Not defined: ovf_o tied 1'b0, no extra flops.
// STRUCTURE
//  lm32_include.v: mode field widths, `LM32_MULT_MODE_RNG (a_signed,b_signed,high), STAGES min/max constants.
//  Sub-module lm32_mult_stage: one valid/data slice with load/hold/kill; instantiated STAGES times via generate.
//  Top holds operand extension, multiplier, half select, overflow logic.
// TESTING
//  1 W=32,S=3, unsigned low: 0xFFFFFFFF*2, out_ready=1 -> result 0xFFFFFFFE two edges after accept; ovf_o=1 if OVF_EN.
//  2 signed high: a=-1 (0xFFFFFFFF),b=3 both signed -> 0xFFFFFFFF; unsigned high same ops -> 0x00000002.
//  3 mixed: a signed -2, b unsigned 0x80000000, high -> 0xFFFFFFFF, low -> 0x00000000.
//  4 stream 8 ops back-to-back, out_ready low for 4 cycles mid-stream -> in_ready drops after 3 held, no loss/dup, order kept.
//  5 kill_i with pipe full and in_valid_i=1 -> next cycle out_valid_o=0, no dropped op ever emitted; next op latency 2.
//  6 async reset asserted between edges with pipe full -> out_valid_o=0, result_o=0 immediately; sweep S=2 and S=6.

Source files
------------

// File: rtl/lm32_mult_pipe_pkg.sv
// Shared types and limits for the lm32_mult_pipe multiplier.
// Mode bits travel with each operation; OVF_W is 1 only in LM32_MULT_OVF_EN builds.
package lm32_mult_pipe_pkg;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
        logic high;
    } mode_t;

    localparam int MODE_W     = $bits(mode_t);
    localparam int STAGES_MIN = 2;
    localparam int STAGES_MAX = 6;

`ifdef LM32_MULT_OVF_EN
    localparam int OVF_W = 1;
`else
    localparam int OVF_W = 0;
`endif

    // Out-of-range depth requests collapse onto the nearest supported depth.
    function automatic int clamp_stages(input int s);
        if (s < STAGES_MIN) return STAGES_MIN;
        if (s > STAGES_MAX) return STAGES_MAX;
        return s;
    endfunction

endpackage

// File: rtl/lm32_mult_stage.sv
// One valid/data pipeline slice: loads when told to, otherwise holds; kill clears valid only.
// Latency 1 cycle; backpressure handled upstream by not asserting load.
// Backpressure: holds valid and data while load is low.
module lm32_mult_stage #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load,
    input  logic          kill,
    input  logic          up_vld,
    input  logic [DW-1:0] up_dat,
    output logic          vld,
    output logic [DW-1:0] dat
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld <= 1'b0;
            dat <= '0;
        end else begin
            if (kill) begin
                vld <= 1'b0;
            end else if (load) begin
                vld <= up_vld;
            end
            if (load) begin
                dat <= up_dat;
            end
        end
    end

endmodule

// File: rtl/lm32_mult_pipe.sv
// Pipelined WIDTHxWIDTH multiplier, signed/unsigned operands, high/low half select, kill; LM32_MULT_OVF_EN adds ovf_o.
// Latency STAGES-1 edges from accept to out_valid_o; one issue per cycle.
// Backpressure: bubble-collapsing valid/ready, output held stable while out_ready_i is low.
module lm32_mult_pipe
    import lm32_mult_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    input  logic             a_signed_i,
    input  logic             b_signed_i,
    input  logic             high_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_o
);

    localparam int S    = clamp_stages(STAGES);
    localparam int D0_W = MODE_W + 2 * WIDTH;
    localparam int DR_W = WIDTH + OVF_W;

    logic [S-1:0]       vld;
    logic [S-1:0]       load;
    mode_t              in_mode;
    mode_t              m0;
    logic [WIDTH-1:0]   a0;
    logic [WIDTH-1:0]   b0;
    logic [D0_W-1:0]    dat0;
    logic [DR_W-1:0]    datr [1:S-1];
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   half;
    logic [DR_W-1:0]    mul_dat;

    assign in_mode.a_signed = a_signed_i;
    assign in_mode.b_signed = b_signed_i;
    assign in_mode.high     = high_i;

    // A stage may load whenever any slot at or beyond it is empty, or the consumer drains the output.
    for (genvar k = 0; k < S; k++) begin : g_load
        assign load[k] = out_ready_i || !(&vld[S-1:k]);
    end

    assign in_ready_o = load[0];

    // Extending to 2*WIDTH directly gives the (WIDTH+1)-bit product already truncated.
    assign {m0, a0, b0} = dat0;
    assign ext_a = {{WIDTH{m0.a_signed & a0[WIDTH-1]}}, a0};
    assign ext_b = {{WIDTH{m0.b_signed & b0[WIDTH-1]}}, b0};
    assign prod  = ext_a * ext_b;
    assign half  = m0.high ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

`ifdef LM32_MULT_OVF_EN
    logic ovf_n;

    always_comb begin
        ovf_n = 1'b0;
        if (!m0.high) begin
            if (m0.a_signed || m0.b_signed) begin
                ovf_n = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
            end else begin
                ovf_n = |prod[2*WIDTH-1:WIDTH];
            end
        end
    end

    assign mul_dat  = {half, ovf_n};
    assign result_o = datr[S-1][DR_W-1 -: WIDTH];
    assign ovf_o    = datr[S-1][0];
`else
    assign mul_dat  = half;
    assign result_o = datr[S-1];
    assign ovf_o    = 1'b0;
`endif

    for (genvar k = 0; k < S; k++) begin : g_stage
        if (k == 0) begin : g_in
            lm32_mult_stage #(.DW(D0_W)) u_stage (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load   (load[0]),
                .kill   (kill_i),
                .up_vld (in_valid_i),
                .up_dat ({in_mode, op_a_i, op_b_i}),
                .vld    (vld[0]),
                .dat    (dat0)
            );
        end else if (k == 1) begin : g_mul
            lm32_mult_stage #(.DW(DR_W)) u_stage (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load   (load[1]),
                .kill   (kill_i),
                .up_vld (vld[0]),
                .up_dat (mul_dat),
                .vld    (vld[1]),
                .dat    (datr[1])
            );
        end else begin : g_pipe
            lm32_mult_stage #(.DW(DR_W)) u_stage (
                .clk_i  (clk_i),
                .rst_i  (rst_i),
                .load   (load[k]),
                .kill   (kill_i),
                .up_vld (vld[k-1]),
                .up_dat (datr[k-1]),
                .vld    (vld[k]),
                .dat    (datr[k])
            );
        end
    end

    assign out_valid_o = vld[S-1];

endmodule
